// File: rtl/program_loader.sv
// Loads a length/data/checksum framed byte stream into CPU RAM by driving the
// shared bus, MAR-in and RAM-in strobes while the CPU is held.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | CPU runs, waiting for start
// WAIT_LEN  | expecting the frame length byte
// WAIT_DATA | expecting the next data byte
// MAR       | drive address onto bus, pulse mi
// WR        | drive data byte onto bus, pulse ri, advance address
// WAIT_SUM  | expecting the checksum byte
// DONE      | one-cycle done pulse, CPU released on the next cycle
// ERR       | sticky error, CPU held until start or clr
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] bus_o,
  output logic              bus_oe,
  output logic              mi,
  output logic              ri,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LEN,
    S_WAIT_DATA,
    S_MAR,
    S_WR,
    S_WAIT_SUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [DATA_W:0] MAX_LEN = (DATA_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W:0]   len_ext;
  logic              accept;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
    end
  end

  assign s_ready  = (state_q == S_WAIT_LEN) || (state_q == S_WAIT_DATA) ||
                    (state_q == S_WAIT_SUM);
  assign accept   = s_valid && s_ready;
  assign len_ext  = {1'b0, s_data};
  assign mi       = (state_q == S_MAR);
  assign ri       = (state_q == S_WR);
  assign bus_oe   = mi || ri;
  assign cpu_hold = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);

  // Address is zero-extended onto the bus during MAR; data byte during WR.
  always_comb begin
    bus_o = '0;
    if (state_q == S_MAR) begin
      bus_o[ADDR_W:0] = addr_q;
    end else if (state_q == S_WR) begin
      bus_o = data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_WAIT_LEN;
          addr_d  = '0;
          sum_d   = '0;
        end
      end
      S_WAIT_LEN: begin
        if (accept) begin
          if ((s_data == '0) || (len_ext > MAX_LEN)) begin
            state_d = S_ERR;
          end else begin
            rem_d   = s_data[ADDR_W:0];
            state_d = S_WAIT_DATA;
          end
        end
      end
      S_WAIT_DATA: begin
        if (accept) begin
          data_d  = s_data;
          sum_d   = sum_q + s_data;
          state_d = S_MAR;
        end
      end
      S_MAR: state_d = S_WR;
      S_WR: begin
        addr_d  = addr_q + ONE;
        rem_d   = rem_q - ONE;
        state_d = (rem_q == ONE) ? S_WAIT_SUM : S_WAIT_DATA;
      end
      S_WAIT_SUM: begin
        if (accept) begin
          state_d = (s_data == sum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
